// File: rtl/in_flip_rt_mc.sv
// in_flip_rt_mc: NCH in-order skid queues with empty bypass, round-robin merged into one registered output (clk, rst async low, flush, in_en/d_in -> pause/cnt/ovf, dout_en -> do_/d_out/d_ch)
module in_flip_rt_mc #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int NCH      = 2,
  parameter int PAUSE_TH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [NCH-1:0]                        in_en,
  input  logic [NCH*WIDTH-1:0]                  d_in,
  output logic [NCH-1:0]                        pause,
  output logic [NCH*($clog2(DEPTH)+1)-1:0]      cnt,
  output logic [NCH-1:0]                        ovf,
  input  logic                                  dout_en,
  output logic                                  do_,
  output logic [WIDTH-1:0]                      d_out,
  output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] d_ch
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  logic [WIDTH-1:0] mem [NCH][DEPTH];
  logic [CW-1:0]    wr [NCH];
  logic [CW-1:0]    rd [NCH];
  logic [CW-1:0]    cq [NCH];
  logic [NCH-1:0]   req, gnt, push;
  logic [SW-1:0]    rr, gc;
  logic             gv, open;
  logic [WIDTH-1:0] src;
  always_comb begin
    open  = !do_ || dout_en;
    gv    = 1'b0;
    gc    = '0;
    gnt   = '0;
    push  = '0;
    req   = '0;
    cnt   = '0;
    pause = '0;
    for (int c = 0; c < NCH; c++) begin
      cq[c] = wr[c] - rd[c];
      req[c] = (cq[c] != '0) || in_en[c];
      cnt[c*CW +: CW] = cq[c];
      pause[c] = (DEPTH - int'(cq[c])) < PAUSE_TH;
    end
    for (int i = 1; i <= NCH; i++)
      if (open && !gv && req[(int'(rr) + i) % NCH]) begin
        gv = 1'b1;
        gc = SW'((int'(rr) + i) % NCH);
      end
    for (int c = 0; c < NCH; c++) begin
      gnt[c] = gv && (gc == SW'(c));
      push[c] = in_en[c] && !(gnt[c] && cq[c] == '0) && (cq[c] != CW'(DEPTH) || gnt[c]);
    end
    src = (cq[gc] != '0) ? mem[gc][rd[gc][AW-1:0]] : d_in[int'(gc)*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr[c] <= '0;
        rd[c] <= '0;
      end
      ovf   <= '0;
      do_   <= 1'b0;
      d_out <= '0;
      d_ch  <= '0;
      rr    <= SW'(NCH - 1);
    end else if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        wr[c] <= '0;
        rd[c] <= '0;
      end
      ovf <= '0;
      do_ <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wr[c] <= wr[c] + CW'(1);
        if (gnt[c] && cq[c] != '0) rd[c] <= rd[c] + CW'(1);
        if (in_en[c] && !push[c] && !(gnt[c] && cq[c] == '0)) ovf[c] <= 1'b1;
      end
      if (open) begin
        do_ <= gv;
        if (gv) begin
          d_out <= src;
          d_ch  <= gc;
          rr    <= gc;
        end
      end
    end
  always_ff @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (push[c] && !flush) mem[c][wr[c][AW-1:0]] <= d_in[c*WIDTH +: WIDTH];
endmodule
